// File: rtl/dmem_bus_pkg.sv
// dmem_bus_pkg: shared definitions for the data-memory load/store path.
//   - access size encodings carried on req_size
//   - store/load polarity of req_we
//   - zero constants for 32- and 64-bit data paths
//   - size_bytes(): number of bytes touched by an access size
package dmem_bus_pkg;

   localparam logic [1:0] SIZE_B = 2'b00;
   localparam logic [1:0] SIZE_H = 2'b01;
   localparam logic [1:0] SIZE_W = 2'b10;
   localparam logic [1:0] SIZE_D = 2'b11;

   localparam logic WRITE_ENABLE = 1'b1;
   localparam logic READ_ENABLE  = 1'b0;

   localparam logic [31:0] ZERO32 = 32'h0000_0000;
   localparam logic [63:0] ZERO64 = 64'h0000_0000_0000_0000;

   function automatic logic [3:0] size_bytes(input logic [1:0] size);
      case (size)
         SIZE_B:  return 4'd1;
         SIZE_H:  return 4'd2;
         SIZE_W:  return 4'd4;
         default: return 4'd8;
      endcase
   endfunction

endpackage

// File: rtl/dmem_align.sv
// dmem_align: combinational lane steering for one memory access.
//   off         byte offset within the memory word
//   size        access size (SIZE_B/H/W/D)
//   is_unsigned zero-extend loads when 1, sign-extend when 0
//   wdata       right-aligned store data
//   rdata_raw   full memory word read at the access index
//   be          per-byte write enables, lanes off .. off+bytes-1
//   wdata_lane  store data shifted into its byte lanes
//   rdata_ext   selected bytes right-aligned and extended to DATA_W
//   misalign    access not naturally aligned, or doubleword on a 32-bit path
module dmem_align
   import dmem_bus_pkg::*;
#(
   parameter  int DATA_W = 32,
   localparam int NB     = DATA_W / 8,
   localparam int OFF_W  = $clog2(NB)
) (
   input  logic [OFF_W-1:0]  off,
   input  logic [1:0]        size,
   input  logic              is_unsigned,
   input  logic [DATA_W-1:0] wdata,
   input  logic [DATA_W-1:0] rdata_raw,
   output logic [NB-1:0]     be,
   output logic [DATA_W-1:0] wdata_lane,
   output logic [DATA_W-1:0] rdata_ext,
   output logic              misalign
);

   logic [3:0]        nbytes;
   logic [4:0]        lane_lo;
   logic [4:0]        lane_hi;
   logic [DATA_W-1:0] rd_shift;
   logic              sign_bit;
   logic              fill_bit;

   assign nbytes     = size_bytes(size);
   assign lane_lo    = 5'(off);
   assign lane_hi    = lane_lo + 5'(nbytes);
   assign wdata_lane = wdata << {off, 3'b000};
   assign rd_shift   = rdata_raw >> {off, 3'b000};

   always_comb begin
      sign_bit = rd_shift[7];
      misalign = 1'b0;
      case (size)
         SIZE_B: sign_bit = rd_shift[7];
         SIZE_H: begin
            sign_bit = rd_shift[15];
            misalign = off[0];
         end
         SIZE_W: begin
            sign_bit = rd_shift[31];
            misalign = |off[1:0];
         end
         default: begin
            // A doubleword cannot exist on a 32-bit path, whatever the offset.
            sign_bit = rd_shift[DATA_W-1];
            misalign = (DATA_W == 32) || (|off);
         end
      endcase
   end

   assign fill_bit = !is_unsigned && sign_bit;

   generate
      for (genvar gi = 0; gi < NB; gi++) begin : g_lane
         assign be[gi] = (5'(gi) >= lane_lo) && (5'(gi) < lane_hi);
         // Bytes beyond the access width are replaced by the extension fill.
         assign rdata_ext[8*gi +: 8] = (4'(gi) < nbytes) ? rd_shift[8*gi +: 8]
                                                          : {8{fill_bit}};
      end
   endgenerate

endmodule

// File: rtl/dmem_bus.sv
// dmem_bus: handshaked data memory for the load/store path.
//   clk, rst            clock and synchronous active-high reset
//   req_valid/req_ready request handshake; one accept per cycle
//   req_we, req_size, req_unsigned, req_addr, req_wdata  request fields
//   rsp_valid/rsp_ready response handshake
//   rsp_rdata, rsp_err  load result (0 for stores/errors) and error flag
// Stores commit at the accept edge; load results appear one cycle after
// accept. Misaligned, illegal-size and out-of-range accesses never touch
// the array and are answered with rsp_err = 1.
module dmem_bus
   import dmem_bus_pkg::*;
#(
   parameter int DATA_W = 32,
   parameter int DEPTH  = 1024,
   parameter int ADDR_W = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_we,
   input  logic [1:0]        req_size,
   input  logic              req_unsigned,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [DATA_W-1:0] req_wdata,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [DATA_W-1:0] rsp_rdata,
   output logic              rsp_err
);

   localparam int NB    = DATA_W / 8;
   localparam int OFF_W = $clog2(NB);
   localparam int IDX_W = $clog2(DEPTH);
   localparam int TOP   = OFF_W + IDX_W;
   localparam logic [DATA_W-1:0] RDATA_ZERO =
      DATA_W'((DATA_W == 64) ? ZERO64 : {ZERO32, ZERO32});

   logic [DATA_W-1:0] mem [DEPTH];

   logic [OFF_W-1:0]  off;
   logic [IDX_W-1:0]  idx;
   logic              out_of_range;
   logic              misalign;
   logic              acc_err;
   logic              accept;
   logic              wr_en;
   logic              is_load;
   logic [NB-1:0]     be;
   logic [DATA_W-1:0] wdata_lane;
   logic [DATA_W-1:0] rd_word;
   logic [DATA_W-1:0] rdata_ext;

   logic              rsp_valid_q, rsp_valid_d;
   logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
   logic              rsp_err_q,   rsp_err_d;

   assign off = req_addr[OFF_W-1:0];
   assign idx = req_addr[TOP-1:OFF_W];

   generate
      if (ADDR_W > TOP) begin : g_range
         assign out_of_range = |req_addr[ADDR_W-1:TOP];
      end else begin : g_no_range
         assign out_of_range = 1'b0;
      end
   endgenerate

   assign rd_word = mem[idx];

   dmem_align #(
      .DATA_W (DATA_W)
   ) u_align (
      .off         (off),
      .size        (req_size),
      .is_unsigned (req_unsigned),
      .wdata       (req_wdata),
      .rdata_raw   (rd_word),
      .be          (be),
      .wdata_lane  (wdata_lane),
      .rdata_ext   (rdata_ext),
      .misalign    (misalign)
   );

   // The response slot frees up in the same cycle the consumer takes it.
   assign req_ready = !rsp_valid_q || rsp_ready;
   // Requests seen while reset is asserted are ignored entirely.
   assign accept    = req_valid && req_ready && !rst;
   assign acc_err   = misalign || out_of_range;
   assign is_load   = (req_we == READ_ENABLE);
   assign wr_en     = accept && (req_we == WRITE_ENABLE) && !acc_err;

   // Array is deliberately not reset so its contents survive rst.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         for (int b = 0; b < NB; b++) begin
            if (be[b]) begin
               mem[idx][8*b +: 8] <= wdata_lane[8*b +: 8];
            end
         end
      end
   end

   always_comb begin
      rsp_valid_d = rsp_valid_q;
      rsp_rdata_d = rsp_rdata_q;
      rsp_err_d   = rsp_err_q;
      if (accept) begin
         rsp_valid_d = 1'b1;
         rsp_err_d   = acc_err;
         rsp_rdata_d = (is_load && !acc_err) ? rdata_ext : RDATA_ZERO;
      end else if (rsp_valid_q && rsp_ready) begin
         rsp_valid_d = 1'b0;
         rsp_rdata_d = RDATA_ZERO;
         rsp_err_d   = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rsp_valid_q <= 1'b0;
         rsp_rdata_q <= RDATA_ZERO;
         rsp_err_q   <= 1'b0;
      end else begin
         rsp_valid_q <= rsp_valid_d;
         rsp_rdata_q <= rsp_rdata_d;
         rsp_err_q   <= rsp_err_d;
      end
   end

   assign rsp_valid = rsp_valid_q;
   assign rsp_rdata = rsp_rdata_q;
   assign rsp_err   = rsp_err_q;

endmodule

// File: doc/dmem_bus.md
Name: dmem_bus

Overview:
- Parametrised data memory for the core's load/store path, replacing the fixed-width word-only data memory.
- Handshaked valid/ready request and response channels, one request accepted per cycle.
- Byte/half/word (and doubleword at 64-bit width) accesses with per-byte write enables and sign/zero extension on loads.
- Detects misaligned and out-of-range accesses and reports them on the response instead of corrupting memory.

Parameters:
- DATA_W, 32, data width in bits; legal values 32 or 64.
- DEPTH, 1024, number of DATA_W-wide words.
- ADDR_W, 32, byte-address width of req_addr.
- Derived: NB = DATA_W/8; OFF_W = log2(NB); IDX_W = log2(DEPTH).

Ports:
- clk  input  1  clock; all logic on the rising edge.
- rst  input  1  reset; synchronous, active-high.
- req_valid  input  1  request present.
- req_ready  output  1  block can accept a request this cycle.
- req_we  input  1  1 = store, 0 = load.
- req_size  input  2  00 byte, 01 half, 10 word, 11 doubleword.
- req_unsigned  input  1  load zero-extends when 1, sign-extends when 0; ignored for stores.
- req_addr  input  ADDR_W  byte address.
- req_wdata  input  DATA_W  store data, right-aligned (bits [8*size_bytes-1:0] used).
- rsp_valid  output  1  response present.
- rsp_ready  input  1  consumer accepts the response.
- rsp_rdata  output  DATA_W  load result, right-aligned and extended; 0 for stores and errors.
- rsp_err  output  1  access was misaligned, illegal size, or out of range.

Behaviour:
- Accept rule: a request is accepted on a rising edge when req_valid && req_ready.
- req_ready = !rsp_valid || rsp_ready. This is combinational from rsp_ready and gives full throughput when the consumer never stalls.
- Address split: off = req_addr[OFF_W-1:0]; idx = req_addr[OFF_W+IDX_W-1:OFF_W].
- Error conditions, evaluated on accept:
  - size 01 with off[0] != 0.
  - size 10 with off[1:0] != 0.
  - size 11 with off != 0.
  - size 11 when DATA_W == 32.
  - any req_addr bit above OFF_W+IDX_W-1 set (out of range).
- On error: no memory write; response has rsp_err = 1 and rsp_rdata = 0.
- Store, no error: byte enables are set for lanes [off .. off+bytes-1]. Lane k receives req_wdata[8*(k-off)+:8]. The write commits at the accept edge. Response: rsp_err = 0, rsp_rdata = 0. Every store is acknowledged.
- Load, no error: select the bytes at off from mem[idx], right-align them, then zero- or sign-extend from bit 8*bytes-1 to DATA_W. The result is registered into rsp_rdata at the accept edge, giving 1-cycle latency (rsp_valid = 1 in the cycle after accept).
- Response register:
  - Loaded on accept.
  - Held stable while rsp_valid && !rsp_ready.
  - Cleared to rsp_valid = 0 after a handshake with no new accept.
  - On handshake plus a new accept in the same cycle, it is replaced by the new response.
- Ordering: a store followed by a load to the same word on the next accepted cycle returns the new data. The store commits before the load reads the array, so no bypass is needed.
- Reset (rst = 1 at an edge), including mid-transaction:
  - rsp_valid = 0, rsp_rdata = 0, rsp_err = 0.
  - req_ready = 1 in the following cycle.
  - Any pending response is dropped.
  - A request presented during reset is not accepted and causes no write.
- Memory array is never reset; its contents survive rst.
- While rsp_valid = 1 and rsp_ready = 0: no accept and no memory write occur.

Decomposition:
- Shared defines file gains:
  - size encodings (SIZE_B, SIZE_H, SIZE_W, SIZE_D).
  - WRITE_ENABLE/READ_ENABLE reuse for req_we.
  - the ZERO32 constant, extended with ZERO64.
- One combinational sub-module, dmem_align:
  - input: off, size, unsigned, wdata, raw read word.
  - output: byte enables, lane-shifted write data, extended load data, misalign flag.
- dmem_bus holds the array, the range check, the handshake and the response register.

Test Plan:
- SW addr 0x10 wdata 0x12345678, then LBU 0x13 -> 0x00000012; LBU 0x10 -> 0x00000078. Both rsp_err = 0, each response 1 cycle after accept.
- SB 0x11 wdata 0xFF, then LB 0x11 -> 0xFFFFFFFF, LBU 0x11 -> 0x000000FF, LW 0x10 -> 0x1234FF78.
- SH 0x12 wdata 0xBEEF, then LH 0x12 -> 0xFFFFBEEF, LHU 0x12 -> 0x0000BEEF, LW 0x10 -> 0xBEEFFF78.
- LW 0x11 and SH 0x13 -> rsp_err = 1, rsp_rdata = 0; a subsequent LW 0x10 is still 0xBEEFFF78. Address 4*DEPTH -> rsp_err = 1.
- Load accepted, then rsp_ready = 0 for 3 cycles with req_valid held -> rsp_rdata stable, req_ready = 0. Second request accepted only in the cycle rsp_ready = 1. Back-to-back loads with rsp_ready = 1 give one response per cycle.
- rst pulsed while rsp_valid = 1 -> next cycle rsp_valid = 0, req_ready = 1. A concurrent SW is not written; LW 0x10 afterwards still returns 0xBEEFFF78.
